// File: rtl/upsample_unit.sv
// -----------------------------------------------------------------------------
// upsample_unit
//
// Nearest-neighbour upsampling stage for the feature-map datapath. Consumes a
// raster stream of XW-lane pixel vectors and emits every pixel scale_x times
// horizontally and scale_y times vertically. The first copy of each input row
// is produced straight from the input stream while the row is written into a
// one-row line buffer. The remaining scale_y-1 copies of the row are replayed
// from that buffer. Lane words are opaque; no arithmetic is performed.
//
// Optional feature (compile-time macro):
//   UPSAMPLE_ZERO_FILL_EN : zero-insertion (unpooling) mode. Only the first
//                           horizontal replica of the first output row carries
//                           the pixel. Every other replica is all-zero.
//                           Handshake and timing are identical to the default
//                           nearest-neighbour mode.
//
// Ports:
//   clk      in   clock, all logic on the rising edge
//   rst      in   synchronous active-high reset
//   data_i   in   XW*QW input pixel vector (lane 0 in the low QW bits)
//   valid_i  in   input vector valid
//   ready_o  out  block accepts data_i this cycle
//   data_o   out  XW*QW output pixel vector
//   valid_o  out  output vector valid
//   ready_i  in   downstream accepts data_o
// -----------------------------------------------------------------------------
module upsample_unit #(
  parameter int scale_x  = 2,
  parameter int scale_y  = 2,
  parameter int ifsize_x = 13,
  parameter int ifsize_y = 13,
  parameter int ofsize_x = 26,
  parameter int ofsize_y = 26,
  parameter int QW       = 32,
  parameter int XW       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XW*QW-1:0]   data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [XW*QW-1:0]   data_o,
  output logic               valid_o,
  input  logic               ready_i
);

  // Geometry sanity checks, evaluated at elaboration.
  generate
    if (scale_x < 1 || scale_y < 1) begin : g_bad_scale
      $error("upsample_unit: scale_x and scale_y must be >= 1");
    end
    if (ofsize_x != ifsize_x * scale_x) begin : g_bad_ofsize_x
      $error("upsample_unit: ofsize_x must equal ifsize_x*scale_x");
    end
    if (ofsize_y != ifsize_y * scale_y) begin : g_bad_ofsize_y
      $error("upsample_unit: ofsize_y must equal ifsize_y*scale_y");
    end
  endgenerate

  localparam int RXW = (scale_x  > 1) ? $clog2(scale_x)  : 1;
  localparam int SYW = (scale_y  > 1) ? $clog2(scale_y)  : 1;
  localparam int IXW = (ifsize_x > 1) ? $clog2(ifsize_x) : 1;
  localparam int IYW = (ifsize_y > 1) ? $clog2(ifsize_y) : 1;

  localparam logic [RXW-1:0] RX_LAST = RXW'(scale_x - 1);
  localparam logic [SYW-1:0] SY_LAST = SYW'(scale_y - 1);
  localparam logic [IXW-1:0] IX_LAST = IXW'(ifsize_x - 1);
  localparam logic [IYW-1:0] IY_LAST = IYW'(ifsize_y - 1);

  typedef enum logic [0:0] {
    FILL   = 1'b0,
    REPLAY = 1'b1
  } state_t;

  // Architectural state
  state_t               state_q;
  logic [XW*QW-1:0]     data_q;
  logic                 valid_q;
  logic [RXW-1:0]       rx_q;
  logic [IXW-1:0]       ix_q;
  logic [IYW-1:0]       iy_q;
  logic [SYW-1:0]       sy_q;

  // One-row line buffer; read combinationally while replaying.
  logic [XW*QW-1:0]     lb_mem [ifsize_x];

  // Next-cycle helpers
  logic                 out_free;
  logic                 fill_load;
  logic                 replay_load;
  logic                 load;
  logic                 row_end;
  logic [XW*QW-1:0]     load_data_d;
  logic [IYW-1:0]       iy_d;

  // The output register can take a new pixel when it is empty or when its
  // last replica is being consumed right now (no bubble between pixels).
  assign out_free    = ~valid_q | (ready_i & (rx_q == RX_LAST));

  // ready_o never looks at valid_i, so no combinational loop can form with an
  // upstream stage that derives valid from ready.
  assign ready_o     = ~rst & (state_q == FILL) & out_free;

  assign fill_load   = valid_i & ready_o;
  assign replay_load = (state_q == REPLAY) & out_free;
  assign load        = fill_load | replay_load;
  assign row_end     = (ix_q == IX_LAST);
  assign load_data_d = (state_q == FILL) ? data_i : lb_mem[ix_q];
  assign iy_d        = (iy_q == IY_LAST) ? '0 : iy_q + IYW'(1);

  // Line-buffer write: only rows arriving from the input stream are stored.
  always_ff @(posedge clk) begin
    if (fill_load) begin
      lb_mem[ix_q] <= data_i;
    end
  end

`ifdef UPSAMPLE_ZERO_FILL_EN
  // Marks that the pixel in data_q came from the input stream, i.e. belongs to
  // output row sy==0 and may therefore be shown on replica rx==0.
  logic                 from_fill_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      from_fill_q <= 1'b0;
    end else if (load) begin
      from_fill_q <= fill_load;
    end
  end

  assign data_o = (from_fill_q && rx_q == '0) ? data_q : '0;
`else
  assign data_o = data_q;
`endif

  assign valid_o = valid_q;

  // Output register, replica counter, raster counters and FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      valid_q <= 1'b0;
      rx_q    <= '0;
      ix_q    <= '0;
      iy_q    <= '0;
      sy_q    <= '0;
    end else begin
      if (load) begin
        // A load wins over draining the last replica, keeping valid_o high.
        data_q  <= load_data_d;
        valid_q <= 1'b1;
        rx_q    <= '0;
        ix_q    <= row_end ? '0 : ix_q + IXW'(1);

        // Row bookkeeping happens when the last pixel of a row is loaded, so
        // the FSM is already back in FILL while that pixel's replicas drain.
        if (row_end) begin
          if (state_q == FILL) begin
            if (scale_y > 1) begin
              state_q <= REPLAY;
              sy_q    <= SYW'(1);
            end else begin
              iy_q    <= iy_d;
            end
          end else begin
            if (sy_q == SY_LAST) begin
              state_q <= FILL;
              sy_q    <= '0;
              iy_q    <= iy_d;
            end else begin
              sy_q    <= sy_q + SYW'(1);
            end
          end
        end
      end else if (valid_q && ready_i) begin
        if (rx_q == RX_LAST) begin
          valid_q <= 1'b0;
        end else begin
          rx_q    <= rx_q + RXW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_upsample_unit.sv
// -----------------------------------------------------------------------------
// tb_upsample_unit
//
// Randomised scoreboard bench for upsample_unit. The driver pushes, for every
// accepted input pixel, the output vectors the frame-level upsampling rule says
// it produces; a separate monitor pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_upsample_unit;

  localparam int IX = 3;
  localparam int IY = 2;
  localparam int SX = 2;
  localparam int SY = 3;
  localparam int QW = 16;
  localparam int XW = 2;
  localparam int W  = QW * XW;

`ifdef UPSAMPLE_ZERO_FILL_EN
  localparam bit ZERO_MODE = 1'b1;
`else
  localparam bit ZERO_MODE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] data_o;
  logic         valid_o;
  logic         ready_i;

  upsample_unit #(
    .scale_x  (SX),
    .scale_y  (SY),
    .ifsize_x (IX),
    .ifsize_y (IY),
    .ofsize_x (IX * SX),
    .ofsize_y (IY * SY),
    .QW       (QW),
    .XW       (XW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  int           out_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] row_buf[$];
  bit           cont_mode = 1'b0;
  bit           seen_out = 1'b0;

  // Output vector for replica k of output row r derived from input pixel p.
  function automatic logic [W-1:0] replica(input logic [W-1:0] p, input int r, input int k);
    if (!ZERO_MODE || (r == 0 && k == 0)) return p;
    return '0;
  endfunction

  // Reference model: an input row yields SY output rows, each pixel SX wide.
  // The first output row is known pixel by pixel; the rest once the row ends.
  task automatic push_pixel(input logic [W-1:0] p);
    for (int k = 0; k < SX; k++) exp_q.push_back(replica(p, 0, k));
    row_buf.push_back(p);
    if (row_buf.size() == IX) begin
      for (int r = 1; r < SY; r++)
        for (int c = 0; c < IX; c++)
          for (int k = 0; k < SX; k++)
            exp_q.push_back(replica(row_buf[c], r, k));
      row_buf.delete();
    end
  endtask

  // Monitor: output comparison, hold-while-stalled, and no-gap checks.
  initial begin
    logic         stall_prev;
    logic [W-1:0] data_prev;
    logic [W-1:0] exp;
    stall_prev = 1'b0;
    data_prev  = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          checks++;
          if (valid_o !== 1'b1 || data_o !== data_prev) begin
            errors++;
            $display("FAIL hold: valid_o=%0b data_o=%h required valid_o=1 data_o=%h",
                     valid_o, data_o, data_prev);
          end
        end
        if (cont_mode && seen_out && exp_q.size() > 0) begin
          checks++;
          if (valid_o !== 1'b1) begin
            errors++;
            $display("FAIL no_gap: valid_o=%b required 1 (pending=%0d)", valid_o, exp_q.size());
          end
        end
        if (cont_mode && valid_o === 1'b1) seen_out = 1'b1;
        if (valid_o === 1'b1 && ready_i === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: data_o=%h required no output", data_o);
          end else begin
            exp = exp_q.pop_front();
            out_cnt++;
            if (data_o !== exp) begin
              errors++;
              $display("FAIL data #%0d: data_o=%h required %h", out_cnt, data_o, exp);
            end else begin
              $display("out #%0d data_o=%h ok", out_cnt, data_o);
            end
          end
        end
        stall_prev = (valid_o === 1'b1) && (ready_i !== 1'b1);
        data_prev  = data_o;
      end
    end
  end

  // Drive npix pixels; vpct/rpct are the percent chances of offering a pixel
  // and of asserting ready_i in a cycle.
  task automatic run_phase(input int npix, input int vpct, input int rpct);
    int sent;
    int guard;
    bit acc;
    sent  = 0;
    guard = 0;
    acc   = 1'b0;
    while (sent < npix && guard < 5000) begin
      @(posedge clk); #1;
      if (acc) valid_i = 1'b0;
      ready_i = ($urandom_range(0, 99) < rpct);
      if (!valid_i && $urandom_range(0, 99) < vpct) begin
        valid_i = 1'b1;
        data_i  = $urandom();
      end
      @(negedge clk);
      if (acc) begin
        checks++;
        if (valid_o !== 1'b1) begin
          errors++;
          $display("FAIL latency: valid_o=%b required 1 one cycle after accept", valid_o);
        end
      end
      acc = valid_i && (ready_o === 1'b1);
      if (acc) push_pixel(data_i);
      if (acc) sent++;
      guard++;
    end
    if (sent < npix) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: sent=%0d required %0d", sent, npix);
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
    if (acc) begin
      @(negedge clk);
      checks++;
      if (valid_o !== 1'b1) begin
        errors++;
        $display("FAIL latency: valid_o=%b required 1 one cycle after accept", valid_o);
      end
    end
  endtask

  task automatic drain(input int rpct);
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 3000) begin
      @(posedge clk); #1;
      ready_i = ($urandom_range(0, 99) < rpct);
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required 0", exp_q.size());
    end
    @(posedge clk); #1;
    ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid: valid_o=%b required 0", valid_o);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_reset: ready_o=%b required 0", ready_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    row_buf.delete();
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: valid_o=%b required 0", valid_o);
    end
  endtask

  initial begin
    rst     = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid_o=%b ready_o=%b required 0 0", valid_o, ready_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready: ready_o=%b required 1", ready_o);
    end

    // Two back-to-back frames at full rate: no output gaps allowed.
    cont_mode = 1'b1;
    seen_out  = 1'b0;
    out_cnt   = 0;
    run_phase(2 * IX * IY, 100, 100);
    drain(100);
    cont_mode = 1'b0;
    checks++;
    if (out_cnt != 2 * IX * IY * SX * SY) begin
      errors++;
      $display("FAIL cont_count: outputs=%0d required %0d", out_cnt, 2 * IX * IY * SX * SY);
    end

    // Random input and output back-pressure over two frames.
    run_phase(2 * IX * IY, 60, 50);
    drain(50);

    // Heavy downstream stall.
    run_phase(IX * IY, 100, 15);
    drain(15);

    // Reset in the middle of a frame, then a full fresh frame from (0,0).
    run_phase(IX + 1, 100, 100);
    repeat (2) @(posedge clk);
    pulse_reset();
    run_phase(2 * IX * IY, 70, 70);
    drain(70);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/upsample_unit.md
# upsample_unit

Nearest-neighbour upsampling stage for the feature-map datapath: it consumes a raster stream of `XW`-lane pixel vectors and emits each pixel replicated scale_x times horizontally and scale_y times vertically. It mirrors the pooling unit: pooling reduces a feature map, this block expands one. It uses the same valid/ready vector stream on both sides, so it chains directly before or after pooling units. The block does no arithmetic; it only replicates lane words. A one-row line buffer replays each input row for the extra output rows.

## Interface
- scale_x, 2, horizontal replication factor (≥1)
- scale_y, 2, vertical replication factor (≥1)
- ifsize_x, 13, input feature-map width in pixels
- ifsize_y, 13, input feature-map height in pixels
- ofsize_x, 26, output width; must equal ifsize_x*scale_x, elaboration `$error` otherwise
- ofsize_y, 26, output height; must equal ifsize_y*scale_y, elaboration `$error` otherwise
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- data_i  in  `QW` × [`XW`]  input pixel vector, lane words are opaque (float32 bits)
- valid_i  in  1  input vector valid
- ready_o  out  1  block accepts data_i this cycle
- data_o  out  `QW` × [`XW`]  output pixel vector
- valid_o  out  1  output vector valid
- ready_i  in  1  downstream accepts data_o

## Operation
- State: output register (pixel, valid_o, replica counter rx 0..scale_x-1), line buffer lb[ifsize_x] of `XW`×`QW`, counters ix (0..ifsize_x-1), iy (0..ifsize_y-1), sy (0..scale_y-1), FSM {FILL, REPLAY}.
- Output register is "free" when ~valid_o, or when valid_o & ready_i & rx==scale_x-1.
- Output handshake: on valid_o & ready_i, rx increments. If rx==scale_x-1 and nothing is loaded that cycle, valid_o clears.
- FILL state (sy=0):
  - ready_o = free.
  - On valid_i & ready_o: write lb[ix]=data_i, load the output register with data_i, rx=0, valid_o=1, advance ix.
  - On the last pixel of a row (ix==ifsize_x-1): if scale_y>1, go to REPLAY with sy=1 and ix=0. Otherwise advance iy.
- REPLAY state:
  - ready_o=0.
  - When free, load the output register from lb[ix] (combinational read), rx=0, then advance ix.
  - At the end of a row: sy increments. When sy reaches scale_y-1 at row end, return to FILL, sy=0, and advance iy.
- Frame wrap: iy==ifsize_y-1 at row completion resets iy=0. The next frame follows with no extra state.
- Simultaneous events: a load in the same cycle as consumption of the last replica takes priority, so valid_o stays 1 with no bubble.
- Reset:
  - Clears valid_o=0, rx, ix, iy, sy and sets state FILL.
  - ready_o=0 while rst=1.
  - lb is not cleared.
  - Reset mid-frame discards the partial frame; the next accepted input is pixel (0,0).

## Timing
- Latency: input accepted at edge n gives valid_o=1 after edge n, i.e. visible in cycle n+1.
- Throughput: one output vector per cycle while ready_i=1, including row, state and frame boundaries.
- Input throughput is 1/(scale_x·scale_y) of output throughput.
- Transition to FILL happens when the last replay pixel is loaded, not when it is consumed. This lets the next input load in the cycle its last replica drains.
- data_o and valid_o hold stable while valid_o & ~ready_i.
- valid_o never depends combinationally on ready_i.
- ready_o depends combinationally on valid_o, ready_i, rx and state only, never on valid_i.

## Configuration
- UPSAMPLE_ZERO_FILL_EN defined: zero-insertion (unpooling) mode.
  - Only replica rx==0 of output row sy==0 carries the pixel.
  - All other replicas output all lanes = `QW'0`.
  - Handshake, counters and timing are unchanged.
- UPSAMPLE_ZERO_FILL_EN undefined: every replica carries the pixel (nearest-neighbour).

## Test plan
- ifsize 2×2, scale 2×2, ready_i=1, inputs A,B,C,D -> outputs A,A,B,B,A,A,B,B,C,C,D,D,C,C,D,D on 16 consecutive cycles; ready_o high only on 4 cycles.
- Same stimulus with ready_i high only when a 0..20 cycle counter >17 -> identical 16-vector sequence; data_o never changes while valid_o&~ready_i.
- Two back-to-back frames, valid_i=1 continuously, ready_i=1 -> 32 outputs with no valid_o gap at the frame boundary.
- scale_x=3, scale_y=1, ifsize 2×1, inputs A,B -> A,A,A,B,B,B; REPLAY never entered.
- rst asserted for 1 cycle after 5 outputs of a frame -> valid_o=0 next cycle; the next input produces row-0 output starting at pixel (0,0).
- UPSAMPLE_ZERO_FILL_EN, 2×2 scale 2×2, inputs A,B,C,D -> A,0,B,0,0,0,0,0,C,0,D,0,0,0,0,0.
